hex_ascii_uart_rx: RTL and testbench
====================================

HEX_ASCII_UART_RX -- requirements
Module: hex_ascii_uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); SHALL be >= 4.
REQ-002 Port: clk  input  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: uart_rx  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-005 Port: word_out  output  32  last fully assembled word; first received char is the MS nibble.
REQ-006 Port: word_valid  output  1  one-cycle pulse; word_out updated this cycle.
REQ-007 Port: char_err  output  1  one-cycle pulse on a non-hex, non-separator byte.
REQ-008 Port: frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-009 Port: char_count  output  4  hex nibbles accumulated toward the current word, 0..7.

Function
REQ-010 uart_rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-011 Receiver FSM states SHALL be IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-012 IDLE: synchronized line low -> START with the bit counter cleared.
REQ-013 START: sample at CLKS_PER_BIT/2; if low -> DATA; if high -> IDLE (glitch rejected, no pulses).
REQ-014 DATA: sample every CLKS_PER_BIT from the start-bit midpoint, 8 bits, LSB first -> STOP.
REQ-015 STOP: sample after CLKS_PER_BIT; if high, the byte is accepted -> IDLE.
REQ-016 STOP: if low, discard the byte, pulse frame_err, leave the parser untouched -> WAIT_IDLE.
REQ-017 WAIT_IDLE: stay until the synchronized line is high -> IDLE.
REQ-018 Parser decode on accepted byte:
  - 0x30-0x39 -> nibble 0-9
  - 0x41-0x46 and 0x61-0x66 -> nibble A-F
  - accumulator = {accumulator[27:0], nibble}; char_count increments
REQ-019 Word completion: when a nibble is accepted with char_count = 7, the cycle after the STOP sample SHALL:
  - load word_out with the 32-bit result
  - pulse word_valid
  - clear char_count and the accumulator
REQ-020 Separators 0x20, 0x0D, 0x0A SHALL silently clear char_count and the accumulator, with no pulse.
REQ-021 Any other byte SHALL pulse char_err and clear char_count and the accumulator, the cycle after the STOP sample.
REQ-022 word_out SHALL hold its value until the next word_valid.
REQ-023 word_valid, char_err and frame_err SHALL be mutually exclusive and never high for two consecutive cycles.
REQ-024 A partial word SHALL never update word_out.
REQ-025 Total latency, stop-bit sample to word_valid, SHALL be exactly 1 clk.
REQ-026 No byte SHALL be lost when a new start bit begins immediately after a stop bit, with no idle gap.

Reset
REQ-027 Asynchronous on reset low, these SHALL take the values given:
  - FSM -> IDLE
  - synchronizer flops -> 1
  - word_out, accumulator, char_count, bit and baud counters -> 0
  - word_valid, char_err, frame_err -> 0
REQ-028 Reset asserted mid-frame or mid-word SHALL abandon the partial byte or word.
REQ-029 After reset deasserts, reception SHALL restart only on a fresh falling edge.

Verification
REQ-030 Send "0000AD69" (CLKS_PER_BIT=16) -> one word_valid, word_out=0x0000AD69, char_count 0 afterwards, no err pulses.
REQ-031 Send "deadBEEF" back-to-back with no idle gap -> word_out=0xDEADBEEF, exactly one word_valid.
REQ-032 Send "12G" then "89ABCDEF" -> char_err pulse after 'G', char_count=0, then word_out=0x89ABCDEF.
REQ-033 Send '5' with stop bit forced low, then "01234567" -> frame_err pulse, char_count unchanged at 0, then word_out=0x01234567.
REQ-034 Low glitch of 0.3 bit time on idle line -> no pulses, FSM returns to IDLE, char_count 0.
REQ-035 Send "1234", assert reset mid-way through the 5th char, release, send "FFFFFFFF" -> word_out=0xFFFFFFFF, single word_valid, no err pulses.

Source files
------------

// File: rtl/hex_ascii_uart_rx.sv
// 8N1 UART receiver feeding an ASCII-hex parser that assembles eight hex
// characters (MS nibble first) into a 32-bit word.
module hex_ascii_uart_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        uart_rx,
    output logic [31:0] word_out,
    output logic        word_valid,
    output logic        char_err,
    output logic        frame_err,
    output logic [3:0]  char_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic [27:0]      accum;
    logic             baud_done;
    logic             bit_sample;
    logic             byte_ok;
    logic             frame_bad;
    logic [4:0]       dec;

    // Returns {is_hex, nibble}; upper and lower case A-F both accepted.
    function automatic logic [4:0] hex_nibble(input logic [7:0] b);
        logic [4:0] r;
        r = 5'd0;
        if (b >= 8'h30 && b <= 8'h39)
            r = {1'b1, b[3:0]};
        else if ((b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66))
            r = {1'b1, b[3:0] + 4'd9};
        return r;
    endfunction

    function automatic logic is_separator(input logic [7:0] b);
        return (b == 8'h20) || (b == 8'h0D) || (b == 8'h0A);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            sync_1 <= uart_rx;
            sync_2 <= sync_1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // START waits half a bit to land on the start-bit midpoint; later states a full bit.
    assign baud_done = (state == START) ? (baud_cnt == HALF_LAST) : (baud_cnt == BIT_LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!sync_2) state_next = START;
            START:     if (baud_done) state_next = sync_2 ? IDLE : DATA;
            DATA:      if (baud_done && bit_cnt == 3'd7) state_next = STOP;
            STOP:      if (baud_done) state_next = sync_2 ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (sync_2) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        bit_sample = 1'b0;
        byte_ok    = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            DATA: bit_sample = baud_done;
            STOP: begin
                byte_ok   = baud_done && sync_2;
                frame_bad = baud_done && !sync_2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
        end else begin
            if (state == IDLE || state == WAIT_IDLE || baud_done)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + 1'b1;
            if (state == IDLE)
                bit_cnt <= 3'd0;
            else if (bit_sample)
                bit_cnt <= bit_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (bit_sample) shift_reg <= {sync_2, shift_reg[7:1]};
    end

    assign dec = hex_nibble(shift_reg);

    // Parser acts on the stop-sample edge so results appear the very next cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_out   <= 32'd0;
            accum      <= 28'd0;
            char_count <= 4'd0;
            word_valid <= 1'b0;
            char_err   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            char_err   <= 1'b0;
            frame_err  <= frame_bad;
            if (byte_ok) begin
                if (dec[4]) begin
                    if (char_count == 4'd7) begin
                        word_out   <= {accum, dec[3:0]};
                        word_valid <= 1'b1;
                        accum      <= 28'd0;
                        char_count <= 4'd0;
                    end else begin
                        accum      <= {accum[23:0], dec[3:0]};
                        char_count <= char_count + 4'd1;
                    end
                end else begin
                    char_err   <= !is_separator(shift_reg);
                    accum      <= 28'd0;
                    char_count <= 4'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_hex_ascii_uart_rx.sv
// Scoreboard bench for hex_ascii_uart_rx: directed scenarios plus random
// character streams checked against a string-level reference model.
module tb_hex_ascii_uart_rx;

    localparam int CPB = 16;
    localparam logic [1:0] K_WORD  = 2'd0;
    localparam logic [1:0] K_CERR  = 2'd1;
    localparam logic [1:0] K_FERR  = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [31:0] word;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        uart_rx = 1'b1;
    logic [31:0] word_out;
    logic        word_valid;
    logic        char_err;
    logic        frame_err;
    logic [3:0]  char_count;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          m_cnt = 0;
    logic [31:0] m_acc = 32'd0;
    logic [31:0] last_word = 32'd0;
    bit          prev_pulse = 1'b0;

    hex_ascii_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .word_out  (word_out),
        .word_valid(word_valid),
        .char_err  (char_err),
        .frame_err (frame_err),
        .char_count(char_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference model: hex value by character class, word after eight nibbles.
    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        int nib;
        exp_t e;
        if (!stop_ok) begin
            e.kind = K_FERR; e.word = 32'd0; exp_q.push_back(e);
            return;
        end
        nib = -1;
        if (b >= "0" && b <= "9")      nib = int'(b) - 48;
        else if (b >= "A" && b <= "F") nib = int'(b) - 65 + 10;
        else if (b >= "a" && b <= "f") nib = int'(b) - 97 + 10;
        if (nib >= 0) begin
            m_acc = m_acc * 16 + 32'(nib);
            m_cnt++;
            if (m_cnt == 8) begin
                e.kind = K_WORD; e.word = m_acc; exp_q.push_back(e);
                m_cnt = 0; m_acc = 0;
            end
        end else begin
            if (!(b == 8'h20 || b == 8'h0D || b == 8'h0A)) begin
                e.kind = K_CERR; e.word = 32'd0; exp_q.push_back(e);
            end
            m_cnt = 0; m_acc = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap_bits);
        model_byte(b, stop_ok);
        @(negedge clk) uart_rx = 1'b0;
        repeat (CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk) uart_rx = b[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk) uart_rx = stop_ok;
        repeat (CPB - 1) @(negedge clk);
        if (gap_bits > 0) begin
            @(negedge clk) uart_rx = 1'b1;
            repeat (gap_bits * CPB - 1) @(negedge clk);
        end
        check("char_count", {28'd0, char_count}, 32'(m_cnt));
    endtask

    task automatic send_str(input string s, input int gap_bits);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, gap_bits);
    endtask

    task automatic idle_bits(input int n);
        @(negedge clk) uart_rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        idle_bits(2);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        int npulse;
        exp_t e;
        npulse = int'(word_valid) + int'(char_err) + int'(frame_err);
        if (npulse > 1) check("pulse_exclusive", 32'(npulse), 32'd1);
        if (npulse > 0 && prev_pulse) check("pulse_back_to_back", 32'd1, 32'd0);
        prev_pulse = (npulse > 0);
        if (npulse > 0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {29'd0, word_valid, char_err, frame_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {30'd0, frame_err ? K_FERR : char_err ? K_CERR : K_WORD},
                      {30'd0, e.kind});
                if (e.kind == K_WORD && word_valid) begin
                    check("word_out", word_out, e.word);
                    last_word = e.word;
                end
            end
        end else if (reset) begin
            check("word_out_hold", word_out, last_word);
        end
    end

    initial begin
        exp_t dummy;
        reset = 1'b0;
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_word_out", word_out, 32'd0);
        check("rst_char_count", {28'd0, char_count}, 32'd0);
        check("rst_pulses", {29'd0, word_valid, char_err, frame_err}, 32'd0);
        reset = 1'b1;
        idle_bits(1);

        send_str("0000AD69", 1);
        check_drained("drain_0000AD69");
        check("word_0000AD69", word_out, 32'h0000AD69);

        send_str("deadBEEF", 0);
        check_drained("drain_deadBEEF");
        check("word_deadBEEF", word_out, 32'hDEADBEEF);

        send_str("12G", 1);
        check("count_after_G", {28'd0, char_count}, 32'd0);
        send_str("89ABCDEF", 0);
        check_drained("drain_89ABCDEF");

        send_byte("5", 1'b0, 2);
        check("count_after_ferr", {28'd0, char_count}, 32'd0);
        send_str("01234567", 1);
        check_drained("drain_01234567");

        send_str("3A", 1);
        @(negedge clk) uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        uart_rx = 1'b1;
        idle_bits(2);
        check("count_after_glitch", {28'd0, char_count}, 32'd2);
        send_str(" ", 1);

        send_str("1234", 1);
        @(negedge clk) uart_rx = 1'b0;
        repeat (CPB * 2 + 5) @(negedge clk);
        last_word = 32'd0;
        reset = 1'b0;
        m_cnt = 0; m_acc = 0;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_word_out", word_out, 32'd0);
        check("midrst_char_count", {28'd0, char_count}, 32'd0);
        reset = 1'b1;
        idle_bits(2);
        send_str("FFFFFFFF", 0);
        check_drained("drain_FFFFFFFF");
        check("word_FFFFFFFF", word_out, 32'hFFFFFFFF);

        for (int n = 0; n < 90; n++) begin
            string hexset;
            int    cat;
            logic [7:0] b;
            hexset = "0123456789abcdefABCDEF";
            cat = int'($urandom_range(0, 11));
            if (cat <= 7) begin
                b = hexset[$urandom_range(0, 21)];
                send_byte(b, 1'b1, int'($urandom_range(0, 1)));
            end else if (cat == 8) begin
                case ($urandom_range(0, 2))
                    0: b = 8'h20;
                    1: b = 8'h0D;
                    default: b = 8'h0A;
                endcase
                send_byte(b, 1'b1, 0);
            end else if (cat == 9 || cat == 10) begin
                b = 8'($urandom_range(0, 255));
                send_byte(b, 1'b1, int'($urandom_range(0, 2)));
            end else begin
                b = 8'($urandom_range(0, 255));
                send_byte(b, 1'b0, 1 + int'($urandom_range(0, 1)));
            end
        end
        check_drained("drain_random");
        while (exp_q.size() > 0) dummy = exp_q.pop_front();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
